two_req_mux_arbiter: RTL
========================

Name: two_req_mux_arbiter

Overview:
Round-robin arbiter that shares a single 2:1 data mux and its output channel between two valid/ready requesters. It owns the mux select, grants one requester at a time, and holds each grant for a bounded burst. This lets two producers drive one downstream consumer without collisions. It sits directly in front of the shared 2:1 mux datapath and replaces free-running select stimulus with a protocol-driven controller.

Parameters:
DATA_W, 8, width of each requester data bus and the output data bus
MAX_BURST, 4, maximum accepted beats per grant while the other requester is waiting (must be at least 1)

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has a beat
req0_data  input  DATA_W  requester 0 data
req0_ready  output  1  beat from requester 0 accepted this cycle
req1_valid  input  1  requester 1 has a beat
req1_data  input  DATA_W  requester 1 data
req1_ready  output  1  beat from requester 1 accepted this cycle
out_valid  output  1  shared output has a beat
out_data  output  DATA_W  shared output data (2:1 mux output)
out_ready  input  1  downstream accepts beat
sel  output  1  registered mux select; 0 means requester 0, 1 means requester 1
busy  output  1  high while in OWN0 or OWN1

Behaviour:
- Reset is asynchronous and active-low; it takes effect immediately and is released synchronously with clk.
  - Reset values: state=IDLE, sel=0, busy=0, out_valid=0, req0_ready=0, req1_ready=0, beat_cnt=0, last_grant=1 (so requester 0 wins the first tie).
- States: IDLE, OWN0, OWN1. sel=1 only in OWN1; sel holds its value in IDLE.
- Datapath is combinational from the registered state:
  - out_data = sel ? req1_data : req0_data.
  - out_valid = (OWN0 and req0_valid) or (OWN1 and req1_valid).
  - reqN_ready = out_ready and state==OWNN. The non-owner's ready is always 0.
- Transfer definition: out_valid and out_ready in the same cycle. beat_cnt counts transfers during the current grant and is reset to 0 on every grant change. Its width is clog2(MAX_BURST+1).
- IDLE transitions:
  - No valid: stay in IDLE.
  - One valid: grant that requester next cycle.
  - Both valid: grant the requester != last_grant.
  - Arbitration latency is 1 cycle from valid to out_valid; no beat is transferred in IDLE.
- OWNx transitions, evaluated every cycle (other = the non-owner):
  - Owner valid low and other valid high: switch to OWN(other) next cycle, with no IDLE bubble.
  - Owner valid low and other valid low: go to IDLE.
  - Transfer this cycle that makes beat_cnt reach MAX_BURST, with other valid high: switch to OWN(other).
  - Same burst-limit transfer with other valid low: stay in OWNx and clear beat_cnt to 0.
  - Otherwise: stay in OWNx.
- last_grant is updated to x on every entry into OWNx.
- The grant is never removed while out_valid=1 and out_ready=0, so stalled data stays stable.
- Requester protocol: once reqN_valid rises it is held, with stable data, until accepted. The arbiter does not check for violations.
- Both valids asserted on the same cycle as reset deassertion: handled as an IDLE tie, so requester 0 wins.
- rst_n asserted mid-burst: the grant is dropped immediately and all outputs return to their reset values; the in-flight beat is not accepted.
- With MAX_BURST=1 and both requesters continuously valid, grants strictly alternate with one beat each.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, no valids -> state IDLE, out_valid=0, both readies 0, sel=0, busy=0.
- Single requester: req1_valid=1 with data 8'hA5, out_ready=1 -> sel=1 and out_valid=1 one cycle later, out_data=8'hA5, req1_ready=1; req0_ready stays 0.
- Tie and round robin: both valid, out_ready=1, MAX_BURST=4 -> 4 beats from req0 (sel=0), then switch to sel=1 with no idle cycle for 4 beats, then back to req0.
- Backpressure: owner req0 holds 8'h3C, out_ready=0 for 5 cycles while req1_valid=1 -> sel stays 0, out_data stays 8'h3C, beat_cnt unchanged; the beat transfers on the first cycle out_ready=1.
- Burst limit, no contender: only req0 valid for 10 beats -> sel stays 0 throughout, beat_cnt wraps 0..3, no IDLE cycles.
- Mid-burst reset: rst_n pulsed low during the second beat of a req1 burst -> outputs return to reset values immediately; after release, a tie grants req0 first.

Source files
------------

// File: rtl/two_req_mux_arbiter.sv
// Round-robin arbiter owning the select of a shared 2:1 valid/ready mux.
// Grants are held for at most MAX_BURST beats while the other side waits.
module two_req_mux_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  state_t        state;
  logic [CW-1:0] beat_cnt;
  logic          last_grant;

  logic own0;
  logic own1;
  logic owner_v;
  logic other_v;
  logic xfer;
  logic at_limit;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);

  assign out_valid  = (own0 & req0_valid) | (own1 & req1_valid);
  assign out_data   = sel ? req1_data : req0_data;
  assign req0_ready = out_ready & own0;
  assign req1_ready = out_ready & own1;
  assign busy       = own0 | own1;

  assign owner_v  = own1 ? req1_valid : req0_valid;
  assign other_v  = own1 ? req0_valid : req1_valid;
  assign xfer     = out_valid & out_ready;
  assign at_limit = xfer && (beat_cnt == CW'(MAX_BURST - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= 1'b0;
      beat_cnt   <= '0;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          // last_grant=1 means requester 0 wins a tie
          if (req0_valid && (!req1_valid || last_grant)) begin
            state      <= OWN0;
            sel        <= 1'b0;
            last_grant <= 1'b0;
            beat_cnt   <= '0;
          end else if (req1_valid) begin
            state      <= OWN1;
            sel        <= 1'b1;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
          end
        end
        OWN0, OWN1: begin
          if ((!owner_v || at_limit) && other_v) begin
            state      <= own0 ? OWN1 : OWN0;
            sel        <= own0;
            last_grant <= own0;
            beat_cnt   <= '0;
          end else if (!owner_v) begin
            state    <= IDLE;
            beat_cnt <= '0;
          end else if (at_limit) begin
            beat_cnt <= '0;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

endmodule
